// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing default, frame shape and transmitter FSM encoding.
package uart_pkg;

  localparam int unsigned DEF_CLK_PER_BIT = 435;
  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned STOP_BITS       = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Small power-of-two FIFO with wrap-bit pointers; a push while full is taken only alongside a pop.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = DATA_BITS
) (
  input  logic             i_clk,
  input  logic             i_n_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [Width-1:0] r_mem [Depth];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // The slot being popped this cycle can take the incoming byte.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a registered-output serialiser.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] Datain,
  input  logic       Datain_valid,
  output logic       Datain_ready,
  output logic       TXD,
  output logic       tx_busy
);

  localparam int unsigned BW     = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int unsigned IW     = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BaudTc  = BW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] LastBit = IW'(DATA_BITS - 1);

  tx_state_e            r_state;
  logic [BW-1:0]        r_baud;
  logic [IW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_sr;
  logic                 r_txd;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_baud_tc;
  logic [DATA_BITS-1:0] w_fifo_data;

  tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_BITS)
  ) u_fifo (
    .i_clk   (clk),
    .i_n_rst (n_rst),
    .i_push  (Datain_valid),
    .i_data  (Datain),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_baud_tc = (r_baud == BaudTc);

  always_comb begin
    w_pop = 1'b0;
    if (!w_empty) begin
      w_pop = (r_state == StIdle) || ((r_state == StStop) && w_baud_tc);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_sr    <= '0;
      r_txd   <= 1'b1;
    end else begin
      // Line level follows the state one cycle later, so TXD is purely registered.
      unique case (r_state)
        StIdle:  r_txd <= 1'b1;
        StStart: r_txd <= 1'b0;
        StData:  r_txd <= r_sr[0];
        StStop:  r_txd <= 1'b1;
      endcase

      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_sr    <= w_fifo_data;
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (w_baud_tc) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= StData;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        StData: begin
          if (w_baud_tc) begin
            r_baud <= '0;
            r_sr   <= r_sr >> 1;
            if (r_bit == LastBit) begin
              r_bit   <= '0;
              r_state <= StStop;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        StStop: begin
          if (w_baud_tc) begin
            r_baud <= '0;
            if (w_pop) begin
              r_sr    <= w_fifo_data;
              r_state <= StStart;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
      endcase
    end
  end

  assign TXD          = r_txd;
  assign Datain_ready = !w_full;
  assign tx_busy      = (r_state != StIdle) || !w_empty;

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter for the hex-calculator lab. Accepts bytes on a valid/ready handshake into a small FIFO and serialises each one on TXD as an 8N1 frame: start bit, 8 data bits LSB first, one stop bit. Sits between the calculator result logic and the board TX pin. Uses the same bit period as the existing receiver so the two loop back directly.

## Interface
- CLK_PER_BIT, default 435: clock cycles per bit; the baud counter counts 0..CLK_PER_BIT-1 (terminal 0x1B2).
- FIFO_DEPTH, default 4: entries in the input buffer; must be a power of 2 and ≥2.
- clk  input  1  system clock, all logic on rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- Datain  input  8  byte to send.
- Datain_valid  input  1  write strobe; byte accepted on a clk edge where Datain_valid && Datain_ready.
- Datain_ready  output  1  FIFO not full.
- TXD  output  1  serial line, idles high.
- tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- Reset values: TXD=1, tx_busy=0, Datain_ready=1, FIFO empty, FSM=IDLE, baud counter=0, bit counter=0.
- FIFO: pointers with one extra wrap bit. full = pointers equal except the MSB. A write when full is dropped silently, with no state change. A simultaneous push and pop is legal in any state, including full, where the pop frees the slot. Count stays unchanged.
- FSM states:
  - IDLE: TXD=1. If the FIFO is non-empty, pop into shift register sr, clear the baud counter, and go to START.
  - START: TXD=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TXD=sr[0]. At each baud terminal count, shift sr right and increment the bit index. After index 7 completes, go to STOP.
  - STOP: TXD=1 for CLK_PER_BIT cycles. At its terminal count:
    - If the FIFO is non-empty, pop and go straight to START (no idle gap).
    - Otherwise go to IDLE.
- Baud counter runs only outside IDLE and restarts at 0 on every pop. Frame timing is therefore independent of write time.
- TXD is driven from a register. No combinational path from Datain to TXD.
- tx_busy = (state != IDLE) || !empty.

## Timing
- Write into an empty FIFO with the FSM in IDLE at edge t:
  - FIFO is non-empty after t.
  - Pop happens at edge t+1.
  - TXD falls after edge t+2 (2-cycle latency).
- Frame length is exactly 10×CLK_PER_BIT cycles. Back-to-back frames have period 10×CLK_PER_BIT with no extra idle cycle.
- Datain_ready deasserts in the cycle after the write that fills the FIFO. It reasserts in the cycle after the pop.
- Reset asserted mid-frame forces TXD=1 immediately (asynchronous) and discards FIFO contents. After release, the first frame starts only after a new write.
- The bit counter stays within 0..7. The baud counter wraps to 0 at CLK_PER_BIT-1 and never exceeds it.

## Structure
- Shared package uart_pkg:
  - CLK_PER_BIT default constant, shared with the receiver.
  - FSM state typedef/encoding: IDLE, START, DATA, STOP.
  - Frame constants: 8 data bits, 1 stop bit.
- One sub-module: tx_fifo (parameterised depth/width, push/pop, full/empty).
- The FSM, baud counter and shift register live in uart_tx.

## Test plan
- Single byte 0x55 after reset, CLK_PER_BIT=435:
  - TXD low from cycle 2 after the write for 435 cycles.
  - Then the data bits 1,0,1,0,1,0,1,0, then high.
  - Sample TXD at bit centres.
- Three bytes 0xA3, 0x00, 0xFF written on consecutive cycles:
  - Frames are contiguous, each 4350 cycles.
  - Decoded bytes match in order.
  - tx_busy falls exactly after the last stop bit.
- Overflow with FIFO_DEPTH=4, 7 writes on consecutive cycles:
  - First write pops at once, so writes 1–5 are accepted.
  - Datain_ready goes low after write 5, and writes 6–7 are dropped.
  - Exactly 5 frames are emitted.
- Push while full during the STOP terminal count (simultaneous pop): the byte is accepted and emitted last.
- Reset asserted in the middle of DATA bit 3 with two bytes queued:
  - TXD=1 and tx_busy=0 immediately.
  - No frame follows after release until a new write.
- Loopback into the existing receiver for all 256 byte values: every Dataout_valid pulse carries the written byte.
